// File: rtl/camo_key_pkg.sv
// camo_key_pkg: shared types and helpers for the camouflage key loader.
//
// Contents:
//   camo_mode_t  - per-gate select encoding {key[2g], key[2g+1]}
//   camo_state_t - loader FSM states
//   mode_of()    - extracts the select pair of gate g from a key bus
package camo_key_pkg;

  // Select pair for one camouflaged gate. The MSB of the pair is key[2g].
  typedef enum logic [1:0] {
    PASS = 2'b00,
    INV  = 2'b01,
    ONE  = 2'b10,
    ZERO = 2'b11
  } camo_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    CHECK = 2'b10
  } camo_state_t;

  // Widest key bus mode_of() accepts; narrower keys are zero-extended.
  localparam int CAMO_MAX_KEY_W = 64;

  function automatic camo_mode_t mode_of(input logic [CAMO_MAX_KEY_W-1:0] key,
                                         input int unsigned              g);
    logic [CAMO_MAX_KEY_W-1:0] sh;
    sh = key >> (2 * g);
    return camo_mode_t'({sh[0], sh[1]});
  endfunction

endpackage

// File: rtl/camo_key_shreg.sv
// camo_key_shreg: shadow register for an incoming key frame.
//
// Bits are written by index (the loader supplies the bit counter), so the
// register never shifts and only the addressed flop toggles. A running XOR
// of every bit written since the last clear is kept alongside.
//
// Ports:
//   clk       in   clock
//   rst_n     in   synchronous active-low reset
//   clr       in   clear shadow and parity (start/restart of a frame)
//   load_en   in   write load_bit into shadow[load_idx]
//   load_idx  in   bit index, IDX_W bits
//   load_bit  in   serial data bit
//   shadow    out  frame contents, FRAME_LEN bits
//   parity    out  XOR of all bits written since the last clear
module camo_key_shreg #(
  parameter int FRAME_LEN = 10,
  parameter int IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 load_en,
  input  logic [IDX_W-1:0]     load_idx,
  input  logic                 load_bit,
  output logic [FRAME_LEN-1:0] shadow,
  output logic                 parity
);

  logic [FRAME_LEN-1:0] shadow_q;
  logic                 parity_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= '0;
      parity_q <= 1'b0;
    end else if (clr) begin
      shadow_q <= '0;
      parity_q <= 1'b0;
    end else if (load_en) begin
      // Decoded write: each flop compares the index against its own
      // position, which keeps index and vector widths independent.
      for (int i = 0; i < FRAME_LEN; i++) begin
        if (load_idx == IDX_W'(i)) begin
          shadow_q[i] <= load_bit;
        end
      end
      parity_q <= parity_q ^ load_bit;
    end
  end

  assign shadow = shadow_q;
  assign parity = parity_q;

endmodule

// File: rtl/camo_key_loader.sv
// camo_key_loader: serial loader for the camouflage select bus of the
// obfuscated c432 core. A frame is shifted LSB-first into a shadow register,
// checked, and committed in a single edge to the held key_out register.
// key_out resets to all zeros, i.e. every gate in pass-through mode.
//
// Build option: define CAMO_KEY_PARITY_EN to append an even-parity bit to
// each frame (FRAME_LEN = KEY_W+1); a frame whose bits do not XOR to zero is
// rejected with key_err. Without it, FRAME_LEN = KEY_W and every complete
// frame commits.
//
// Ports:
//   clk            in   clock
//   rst_n          in   synchronous active-low reset
//   load_start     in   pulse: begin (IDLE) or restart (SHIFT) a frame load
//   key_sdi        in   serial key bit
//   key_sdi_valid  in   key_sdi qualifier
//   key_busy       out  high in SHIFT and CHECK
//   key_done       out  one-cycle pulse after a successful commit
//   key_err        out  one-cycle pulse after a parity failure or timeout
//   key_valid      out  sticky: a key has been committed since reset
//   key_out        out  committed select bits, key_out[i] drives D_i
//
// Handshake: there is no back-pressure. While in SHIFT, key_sdi is consumed
// on every cycle key_sdi_valid is high (unless load_start is also high, which
// restarts the frame instead); outside SHIFT key_sdi_valid is ignored.
module camo_key_loader
  import camo_key_pkg::*;
#(
  parameter  int NUM_GATES = 5,
  parameter  int TIMEOUT   = 64,
  localparam int KEY_W     = 2 * NUM_GATES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             key_sdi,
  input  logic             key_sdi_valid,
  output logic             key_busy,
  output logic             key_done,
  output logic             key_err,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_out
);

`ifdef CAMO_KEY_PARITY_EN
  localparam int FRAME_LEN = KEY_W + 1;
`else
  localparam int FRAME_LEN = KEY_W;
`endif

  // Wide enough to hold FRAME_LEN and TIMEOUT themselves: no wrap-around.
  localparam int BC_W = $clog2(FRAME_LEN + 1);
  localparam int TC_W = $clog2(TIMEOUT + 1);

  camo_state_t          state_q, state_d;
  logic [BC_W-1:0]      bit_cnt_q;
  logic [TC_W-1:0]      tmo_cnt_q;
  logic [KEY_W-1:0]     key_q;
  logic                 valid_q;
  logic                 done_q;
  logic                 err_q;

  logic                 frame_clr;
  logic                 bit_accept;
  logic                 tmo_inc;
  logic                 commit;
  logic                 fail;

  logic [FRAME_LEN-1:0] shadow;
  logic                 parity;
  logic                 frame_ok;

  camo_key_shreg #(
    .FRAME_LEN (FRAME_LEN),
    .IDX_W     (BC_W)
  ) u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (frame_clr),
    .load_en  (bit_accept),
    .load_idx (bit_cnt_q),
    .load_bit (key_sdi),
    .shadow   (shadow),
    .parity   (parity)
  );

`ifdef CAMO_KEY_PARITY_EN
  // Even parity over key and parity bit together.
  assign frame_ok = ~parity;
  logic unused_parity_bit;
  assign unused_parity_bit = shadow[FRAME_LEN-1];
`else
  assign frame_ok = 1'b1;
  logic unused_parity;
  assign unused_parity = parity;
`endif

  // ---------------------------------------------------------------------
  // Next-state and control
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    frame_clr  = 1'b0;
    bit_accept = 1'b0;
    tmo_inc    = 1'b0;
    commit     = 1'b0;
    fail       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d   = SHIFT;
          frame_clr = 1'b1;
        end
      end

      SHIFT: begin
        if (load_start) begin
          // Restart beats a bit arriving in the same cycle.
          frame_clr = 1'b1;
        end else if (tmo_cnt_q == TC_W'(TIMEOUT)) begin
          // Timeout also beats a late bit; the frame is abandoned.
          state_d = IDLE;
          fail    = 1'b1;
        end else if (key_sdi_valid) begin
          bit_accept = 1'b1;
          if (bit_cnt_q == BC_W'(FRAME_LEN - 1)) begin
            state_d = CHECK;
          end
        end else begin
          tmo_inc = 1'b1;
        end
      end

      CHECK: begin
        state_d = IDLE;
        if (frame_ok) begin
          commit = 1'b1;
        end else begin
          fail = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State, counters and commit register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      tmo_cnt_q <= '0;
      key_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;

      if (frame_clr) begin
        bit_cnt_q <= '0;
      end else if (bit_accept) begin
        bit_cnt_q <= bit_cnt_q + BC_W'(1);
      end

      if (frame_clr || bit_accept) begin
        tmo_cnt_q <= '0;
      end else if (tmo_inc) begin
        tmo_cnt_q <= tmo_cnt_q + TC_W'(1);
      end

      // key_out only moves here, so the core never sees a partial key.
      if (commit) begin
        key_q   <= shadow[KEY_W-1:0];
        valid_q <= 1'b1;
      end

      // commit and fail are never both set, so these stay exclusive.
      done_q <= commit;
      err_q  <= fail;
    end
  end

  assign key_busy  = (state_q == SHIFT) || (state_q == CHECK);
  assign key_done  = done_q;
  assign key_err   = err_q;
  assign key_valid = valid_q;
  assign key_out   = key_q;

endmodule
